// File: rtl/axi_ipc_mailbox.sv
// rtl/axi_ipc_mailbox.sv - AXI4-Lite IPC mailbox: word FIFO, status/irq registers, level interrupt
module axi_ipc_mailbox #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  irq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_RXDATA = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_IER    = 3'd3;
    localparam logic [2:0] OFF_ISR    = 3'd4;
    localparam logic [2:0] OFF_THRESH = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    // FIFO storage and control/status registers
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, unf_q;
    logic [2:0]    ier_q;
    logic [7:0]    thresh_q;
    logic          irq_q;

    // Write channel state
    w_state_e      w_state_q;
    logic          awready_q, wready_q, bvalid_q;
    logic [1:0]    bresp_q;
    logic          aw_held_q, w_held_q;
    logic [2:0]    awaddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    // Read channel state
    r_state_e      r_state_q;
    logic          arready_q, rvalid_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;

    // Combinational decode results
    logic          aw_hs, w_hs, ar_hs, wr_fire;
    logic [2:0]    wr_off;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          push, pop, ovf_set, unf_set, ier_we, thresh_we, err_clr;
    logic [1:0]    bresp_d, rresp_d;
    logic [31:0]   rdata_d;
    logic          fifo_empty, fifo_full, thresh_hit;
    logic [7:0]    count8;
    logic [2:0]    isr_w;
    logic [31:0]   status_w;
    logic          unused_addr;

    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign irq           = irq_q;

    // Status levels derived from the registered FIFO state (start-of-cycle view)
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        count8     = 8'(count_q);
        thresh_hit = (count8 >= thresh_q);
        isr_w      = {ovf_q | unf_q, thresh_hit, !fifo_empty};
        status_w   = {16'd0, count8, 4'd0, unf_q, ovf_q, fifo_full, fifo_empty};
    end

    // Write decode: a write completes once both address and data are available
    always_comb begin
        aw_hs     = s_axi_awvalid && awready_q;
        w_hs      = s_axi_wvalid && wready_q;
        wr_fire   = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_off    = aw_held_q ? awaddr_q : s_axi_awaddr[4:2];
        wr_data   = w_held_q ? wdata_q : s_axi_wdata;
        wr_strb   = w_held_q ? wstrb_q : s_axi_wstrb;
        push      = 1'b0;
        ovf_set   = 1'b0;
        ier_we    = 1'b0;
        thresh_we = 1'b0;
        err_clr   = 1'b0;
        bresp_d   = RESP_OKAY;
        if (wr_fire) begin
            case (wr_off)
                OFF_TXDATA: begin
                    if (wr_strb != 4'hF) begin
                        bresp_d = RESP_SLVERR;
                    end else if (fifo_full) begin
                        ovf_set = 1'b1;
                        bresp_d = RESP_SLVERR;
                    end else begin
                        push = 1'b1;
                    end
                end
                OFF_IER:    ier_we    = wr_strb[0];
                OFF_ISR:    err_clr   = wr_data[2];
                OFF_THRESH: thresh_we = 1'b1;
                default:    ;
            endcase
        end
    end

    // Read decode: executes on the AR handshake, popping RXDATA when non-empty
    always_comb begin
        ar_hs   = s_axi_arvalid && arready_q;
        pop     = 1'b0;
        unf_set = 1'b0;
        rdata_d = 32'd0;
        rresp_d = RESP_OKAY;
        if (ar_hs) begin
            case (s_axi_araddr[4:2])
                OFF_RXDATA: begin
                    if (fifo_empty) begin
                        unf_set = 1'b1;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        pop     = 1'b1;
                        rdata_d = mem_q[rd_ptr_q];
                    end
                end
                OFF_STATUS: rdata_d = status_w;
                OFF_IER:    rdata_d = {29'd0, ier_q};
                OFF_ISR:    rdata_d = {29'd0, isr_w};
                OFF_THRESH: rdata_d = {24'd0, thresh_q};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    // Write channel FSM: latch AW and W independently, respond once both are in
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (wr_fire) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= bresp_d;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_axi_awaddr[4:2];
                            awready_q <= 1'b0;
                        end else if (!aw_held_q) begin
                            awready_q <= 1'b1;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axi_wdata;
                            wstrb_q  <= s_axi_wstrb;
                            wready_q <= 1'b0;
                        end else if (!w_held_q) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Read channel FSM: capture data on AR handshake and hold it until accepted
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO pointers, occupancy, sticky errors, config registers and irq
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ier_q    <= 3'd0;
            thresh_q <= 8'd1;
            irq_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            if (ovf_set)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (unf_set)      unf_q <= 1'b1;
            else if (err_clr) unf_q <= 1'b0;
            if (ier_we)    ier_q    <= wr_data[2:0];
            if (thresh_we) thresh_q <= wr_data[7:0];
            irq_q <= |(isr_w & ier_q);
        end
    end

    // FIFO storage write port; contents are meaningless after reset
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule
